// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Width-generic multi-cycle ALU with a valid/ready handshake on
//            both sides. Seven single-cycle ops plus an iterative shift-add
//            multiply. The result and the Z/N/V flags are registered.
// Options  : ALU_SAT_EN - when defined, add/sub clamp to the signed extreme
//            on overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
   parameter int W   = 16,
   parameter int SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] Ain,
   input  logic [W-1:0] Bin,
   input  logic [2:0]   ALUop,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         Z,
   output logic         N,
   output logic         V
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0]     OP_ADD  = 3'b000;
   localparam logic [2:0]     OP_SUB  = 3'b001;
   localparam logic [2:0]     OP_AND  = 3'b010;
   localparam logic [2:0]     OP_NOTB = 3'b011;
   localparam logic [2:0]     OP_OR   = 3'b100;
   localparam logic [2:0]     OP_XOR  = 3'b101;
   localparam logic [2:0]     OP_SHL  = 3'b110;
   localparam logic [2:0]     OP_MUL  = 3'b111;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(W - 1);

   state_t           state_q, state_d;
   logic [W-1:0]     acap_q, acap_d;
   logic [W-1:0]     bcap_q, bcap_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]     out_q, out_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             v_q, v_d;

   logic [W-1:0]     add_b;
   logic             add_cin;
   logic [W-1:0]     add_sum;
   logic             add_ovf;
   logic [W-1:0]     alu_res;
   logic             alu_v;
   logic [2*W-1:0]   mul_addend;
   logic [2*W-1:0]   acc_next;

   // Single-cycle datapath evaluated directly on the presented operands
   always_comb begin
      add_b   = (ALUop == OP_SUB) ? ~Bin : Bin;
      add_cin = (ALUop == OP_SUB);
      add_sum = Ain + add_b + {{(W-1){1'b0}}, add_cin};
      // Per-bit identity: carry-in xor carry-out at the MSB equals
      // "operands share a sign that the result does not".
      add_ovf = (Ain[W-1] == add_b[W-1]) && (add_sum[W-1] != Ain[W-1]);
`ifdef ALU_SAT_EN
      // On overflow the true result carries the sign of A.
      if (add_ovf) begin
         add_sum = Ain[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
`endif
      alu_res = '0;
      alu_v   = 1'b0;
      case (ALUop)
         OP_ADD,
         OP_SUB:  begin alu_res = add_sum; alu_v = add_ovf; end
         OP_AND:  alu_res = Ain & Bin;
         OP_NOTB: alu_res = ~Bin;
         OP_OR:   alu_res = Ain | Bin;
         OP_XOR:  alu_res = Ain ^ Bin;
         OP_SHL:  alu_res = Ain << Bin[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   // One shift-add multiply step on the captured operands
   always_comb begin
      mul_addend = '0;
      if (bcap_q[cnt_q]) begin
         mul_addend = {{W{1'b0}}, acap_q} << cnt_q;
      end
      acc_next = acc_q + mul_addend;
   end

   // Next-state, handshake outputs and result/flag updates
   always_comb begin
      state_d   = state_q;
      acap_d    = acap_q;
      bcap_d    = bcap_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      z_d       = z_q;
      n_d       = n_q;
      v_d       = v_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (ALUop == OP_MUL) begin
                  acap_d  = Ain;
                  bcap_d  = Bin;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_MUL;
               end else begin
                  out_d   = alu_res;
                  z_d     = (alu_res == '0);
                  n_d     = alu_res[W-1];
                  v_d     = alu_v;
                  state_d = S_DONE;
               end
            end
         end
         S_MUL: begin
            acc_d = acc_next;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == CNT_LAST) begin
               out_d   = acc_next[W-1:0];
               z_d     = (acc_next[W-1:0] == '0);
               n_d     = acc_next[W-1];
               v_d     = |acc_next[2*W-1:W];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acap_q  <= '0;
         bcap_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         acap_q  <= acap_d;
         bcap_q  <= bcap_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
      end
   end

   assign out = out_q;
   assign Z   = z_q;
   assign N   = n_q;
   assign V   = v_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc (W=16). Expected values
//            are hand-computed; ALU_SAT_EN selects the clamped expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

   localparam int W = 16;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] Ain;
   logic [W-1:0] Bin;
   logic [2:0]   ALUop;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         Z;
   logic         N;
   logic         V;

   int total = 0;
   int bad   = 0;

   alu_mc #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Ain       (Ain),
      .Bin       (Bin),
      .ALUop     (ALUop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .Z         (Z),
      .N         (N),
      .V         (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle. Presents one op, lets it be
   // accepted, scrambles the inputs, then counts negedges until out_valid.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, output int lat, output bit rdy_hi);
      Ain      = a;
      Bin      = b;
      ALUop    = op;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      Ain      = W'($urandom);
      Bin      = W'($urandom);
      ALUop    = 3'($urandom);
      lat      = 0;
      rdy_hi   = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
         if (in_ready) rdy_hi = 1'b1;
      end
   endtask

   initial begin
      int lat;
      bit rdy_hi;
      bit ov_seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      Ain       = '0;
      Bin       = '0;
      ALUop     = 3'b000;

      // Reset for two edges, then release
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out",      32'(out),       32'h0);
      chk("rst_z",        32'(Z),         32'h0);
      chk("rst_n",        32'(N),         32'h0);
      chk("rst_v",        32'(V),         32'h0);
      chk("rst_ovalid",   32'(out_valid), 32'h0);
      chk("rst_inready",  32'(in_ready),  32'h1);

      // Add with signed overflow
      run_op(16'h7FFF, 16'h0001, 3'b000, lat, rdy_hi);
      chk("add_lat", 32'(lat), 32'd1);
`ifdef ALU_SAT_EN
      chk("add_out", 32'(out), 32'h7FFF);
      chk("add_n",   32'(N),   32'h0);
`else
      chk("add_out", 32'(out), 32'h8000);
      chk("add_n",   32'(N),   32'h1);
`endif
      chk("add_v",   32'(V),   32'h1);
      chk("add_z",   32'(Z),   32'h0);
      @(negedge clk);
      chk("add_back_idle", 32'(in_ready), 32'h1);

      // Sub to zero
      run_op(16'h0005, 16'h0005, 3'b001, lat, rdy_hi);
      chk("sub_out", 32'(out), 32'h0);
      chk("sub_z",   32'(Z),   32'h1);
      chk("sub_v",   32'(V),   32'h0);
      @(negedge clk);

      // Sub with overflow: 0x8000 - 1
      run_op(16'h8000, 16'h0001, 3'b001, lat, rdy_hi);
`ifdef ALU_SAT_EN
      chk("subov_out", 32'(out), 32'h8000);
`else
      chk("subov_out", 32'(out), 32'h7FFF);
`endif
      chk("subov_v", 32'(V), 32'h1);
      @(negedge clk);

      // Plain add, no overflow
      run_op(16'h1234, 16'h1111, 3'b000, lat, rdy_hi);
      chk("add2_out", 32'(out), 32'h2345);
      chk("add2_v",   32'(V),   32'h0);
      @(negedge clk);

      // Logic ops
      run_op(16'hF0F0, 16'hFF00, 3'b010, lat, rdy_hi);
      chk("and_out", 32'(out), 32'hF000);
      chk("and_n",   32'(N),   32'h1);
      @(negedge clk);
      run_op(16'hF0F0, 16'hFF00, 3'b011, lat, rdy_hi);
      chk("notb_out", 32'(out), 32'h00FF);
      @(negedge clk);
      run_op(16'hF0F0, 16'hFF00, 3'b100, lat, rdy_hi);
      chk("or_out", 32'(out), 32'hFFF0);
      @(negedge clk);
      run_op(16'hF0F0, 16'hFF00, 3'b101, lat, rdy_hi);
      chk("xor_out", 32'(out), 32'h0FF0);
      @(negedge clk);

      // Shift uses only the low 4 bits of B
      run_op(16'h0003, 16'hFFF4, 3'b110, lat, rdy_hi);
      chk("shl_out", 32'(out), 32'h0030);
      chk("shl_v",   32'(V),   32'h0);
      @(negedge clk);

      // Multiply with high-half overflow
      run_op(16'h0100, 16'h0101, 3'b111, lat, rdy_hi);
      chk("mul1_lat",   32'(lat),    32'd17);
      chk("mul1_rdy0",  32'(rdy_hi), 32'h0);
      chk("mul1_out",   32'(out),    32'h0100);
      chk("mul1_v",     32'(V),      32'h1);
      @(negedge clk);
      run_op(16'h0003, 16'h0005, 3'b111, lat, rdy_hi);
      chk("mul2_out", 32'(out), 32'h000F);
      chk("mul2_v",   32'(V),   32'h0);
      @(negedge clk);
      run_op(16'hFFFF, 16'hFFFF, 3'b111, lat, rdy_hi);
      chk("mul3_out", 32'(out), 32'h0001);
      chk("mul3_v",   32'(V),   32'h1);
      chk("mul3_n",   32'(N),   32'h0);
      @(negedge clk);

      // Backpressure: result held while out_ready is low, new op ignored
      out_ready = 1'b0;
      run_op(16'h0001, 16'h0002, 3'b000, lat, rdy_hi);
      chk("bp_lat", 32'(lat), 32'd1);
      Ain      = 16'h0009;
      Bin      = 16'h0009;
      ALUop    = 3'b000;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_out",     32'(out),       32'h0003);
         chk("bp_ovalid",  32'(out_valid), 32'h1);
         chk("bp_inready", 32'(in_ready),  32'h0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ovalid", 32'(out_valid), 32'h0);
      chk("bp_release_out",    32'(out),       32'h0003);
      @(negedge clk);
      @(negedge clk);
      chk("bp_no_accept", 32'(out_valid), 32'h0);

      // Abort a multiply with reset partway through
      Ain      = 16'h0003;
      Bin      = 16'h0005;
      ALUop    = 3'b111;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int c = 0; c < 7; c++) @(negedge clk);
      chk("abort_busy", 32'(in_ready), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_idle",   32'(in_ready),  32'h1);
      chk("abort_ovalid", 32'(out_valid), 32'h0);
      chk("abort_out",    32'(out),       32'h0);
      ov_seen = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      chk("abort_no_result", 32'(ov_seen), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
